// File: rtl/mem_ctrl_pkg.sv
// Shared widths, constants and arbiter state encodings for the memory controller.
package mem_ctrl_pkg;
  localparam int          ByteBus     = 8;
  localparam int          InstAddrBus = 32;
  localparam logic        Enable      = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0;

  // One bit per owner, so the grant outputs come straight off the state flops.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_MEM  = 2'b10
  } arb_state_t;
endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Two-requester arbiter for the single RAM port. MEM wins ties out of IDLE.
// An owner keeps the port while it requests or is busy. It is released only
// once its outstanding reads have drained. Ownership always passes through IDLE.
module mem_ctrl_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_busy,
  input  logic mem_req,
  input  logic mem_busy,
  input  logic pipe_empty,
  output logic if_grant_o,
  output logic mem_grant_o
);

  arb_state_t state_q, state_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: arbitrate in IDLE, hold while the owner is active or reads are in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_req)     state_d = ARB_MEM;
        else if (if_req) state_d = ARB_IF;
      end
      ARB_IF:  if (!if_req && !if_busy && pipe_empty)   state_d = ARB_IDLE;
      ARB_MEM: if (!mem_req && !mem_busy && pipe_empty) state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant outputs decode the registered state, so they change only at clock edges.
  always_comb begin
    if_grant_o  = (state_q == ARB_IF);
    mem_grant_o = (state_q == ARB_MEM);
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide memory controller. IF and MEM share one synchronous single-port RAM.
// Reads return two cycles after accept. Each read is routed by the owner tag it
// carried at accept time, not by the current grant.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = InstAddrBus,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_r_i,
  input  logic [ADDR_WIDTH-1:0]     if_addr_i,
  input  logic                      if_busy_i,
  output logic                      if_grant_o,
  output logic                      if_rvalid_o,
  output logic [ByteBus-1:0]        if_data_o,
  input  logic                      mem_r_i,
  input  logic                      mem_w_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [ByteBus-1:0]        mem_wdata_i,
  input  logic                      mem_busy_i,
  output logic                      mem_grant_o,
  output logic                      mem_rvalid_o,
  output logic [ByteBus-1:0]        mem_data_o,
  output logic                      mem_wdone_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic                      ram_wr_o,
  output logic [ByteBus-1:0]        ram_dout_o,
  input  logic [ByteBus-1:0]        ram_din_i
);

  // In-flight reads: stage 0 = address presented, stage 1 = RAM data on ram_din_i.
  logic [1:0] vld_pipe;
  logic [1:0] own_pipe;   // 1 = MEM owns the read, 0 = IF
  logic       pipe_empty;
  logic       wr_acc, if_rd_acc, mem_rd_acc;
  logic       unused_addr_hi;

  assign pipe_empty = ~|vld_pipe;
  // A write takes priority over a simultaneous read from MEM.
  assign wr_acc     = mem_grant_o & mem_w_i;
  assign mem_rd_acc = mem_grant_o & mem_r_i & ~mem_w_i;
  assign if_rd_acc  = if_grant_o & if_r_i;
  // Upper address bits are deliberately dropped; the RAM space wraps.
  assign unused_addr_hi = ^{if_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                            mem_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH]};

  mem_ctrl_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_r_i),
    .if_busy     (if_busy_i),
    .mem_req     (mem_r_i | mem_w_i),
    .mem_busy    (mem_busy_i),
    .pipe_empty  (pipe_empty),
    .if_grant_o  (if_grant_o),
    .mem_grant_o (mem_grant_o)
  );

  // RAM command side: drive address, strobe and write data for each accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= '0;
      mem_wdone_o <= 1'b0;
    end else begin
      ram_wr_o    <= wr_acc;
      mem_wdone_o <= wr_acc;
      if (wr_acc) begin
        ram_addr_o <= mem_addr_i[RAM_ADDR_WIDTH-1:0];
        ram_dout_o <= mem_wdata_i;
      end else if (if_rd_acc) begin
        ram_addr_o <= if_addr_i[RAM_ADDR_WIDTH-1:0];
      end else if (mem_rd_acc) begin
        ram_addr_o <= mem_addr_i[RAM_ADDR_WIDTH-1:0];
      end
    end
  end

  // Tag pipe: shift each accepted read's valid bit and owner through the two-cycle RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], if_rd_acc | mem_rd_acc};
      own_pipe <= {own_pipe[0], mem_rd_acc};
    end
  end

  // Return side: capture the RAM byte into the owner's data register and pulse its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid_o  <= 1'b0;
      mem_rvalid_o <= 1'b0;
      if_data_o    <= '0;
      mem_data_o   <= '0;
    end else begin
      if_rvalid_o  <= vld_pipe[1] & ~own_pipe[1];
      mem_rvalid_o <= vld_pipe[1] &  own_pipe[1];
      if (vld_pipe[1] & ~own_pipe[1]) if_data_o  <= ram_din_i;
      if (vld_pipe[1] &  own_pipe[1]) mem_data_o <= ram_din_i;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural synchronous byte RAM.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_r_i, if_busy_i;
  logic [31:0] if_addr_i;
  logic        if_grant_o, if_rvalid_o;
  logic [7:0]  if_data_o;
  logic        mem_r_i, mem_w_i, mem_busy_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_wdata_i;
  logic        mem_grant_o, mem_rvalid_o, mem_wdone_o;
  logic [7:0]  mem_data_o;
  logic [16:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i = 8'h00;

  logic [7:0]  ram [0:131071];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_r_i       (if_r_i),
    .if_addr_i    (if_addr_i),
    .if_busy_i    (if_busy_i),
    .if_grant_o   (if_grant_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_data_o    (if_data_o),
    .mem_r_i      (mem_r_i),
    .mem_w_i      (mem_w_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_busy_i   (mem_busy_i),
    .mem_grant_o  (mem_grant_o),
    .mem_rvalid_o (mem_rvalid_o),
    .mem_data_o   (mem_data_o),
    .mem_wdone_o  (mem_wdone_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wr_o     (ram_wr_o),
    .ram_dout_o   (ram_dout_o),
    .ram_din_i    (ram_din_i)
  );

  // Synchronous single-port RAM: data for the registered address is valid one cycle later.
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      $error("check %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Return-side snapshot: both valids and the owner's data when its valid is expected.
  task automatic chk_ret(input string tag, input logic ifv, input logic [7:0] ifd,
                         input logic memv, input logic [7:0] memd);
    chk({tag, ".if_rvalid"},  32'(if_rvalid_o),  32'(ifv));
    chk({tag, ".mem_rvalid"}, 32'(mem_rvalid_o), 32'(memv));
    if (ifv)  chk({tag, ".if_data"},  32'(if_data_o),  32'(ifd));
    if (memv) chk({tag, ".mem_data"}, 32'(mem_data_o), 32'(memd));
  endtask

  task automatic chk_grants(input string tag, input logic ifg, input logic memg);
    chk({tag, ".if_grant"},  32'(if_grant_o),  32'(ifg));
    chk({tag, ".mem_grant"}, 32'(mem_grant_o), 32'(memg));
  endtask

  initial begin
    ram[17'h00100] <= 8'h13;
    ram[17'h00101] <= 8'h05;
    ram[17'h00102] <= 8'h10;
    ram[17'h00103] <= 8'h00;
    ram[17'h00005] <= 8'h5A;
    rst = 1'b1;
    if_r_i = 1'b0; if_busy_i = 1'b0; if_addr_i = 32'h0;
    mem_r_i = 1'b0; mem_w_i = 1'b0; mem_busy_i = 1'b0;
    mem_addr_i = 32'h0; mem_wdata_i = 8'h0;
    step(); step();

    // Reset state
    chk_grants("rst", 1'b0, 1'b0);
    chk_ret("rst", 1'b0, 8'h00, 1'b0, 8'h00);
    chk("rst.if_data",  32'(if_data_o),   32'h0);
    chk("rst.mem_data", 32'(mem_data_o),  32'h0);
    chk("rst.wdone",    32'(mem_wdone_o), 32'h0);
    chk("rst.ram_addr", 32'(ram_addr_o),  32'h0);
    chk("rst.ram_wr",   32'(ram_wr_o),    32'h0);
    chk("rst.ram_dout", 32'(ram_dout_o),  32'h0);
    rst = 1'b0;

    // IF fetch of four bytes from 0x100
    if_r_i = 1'b1; if_busy_i = 1'b1; if_addr_i = 32'h100;
    step(); chk_grants("f.grant", 1'b1, 1'b0);
    step(); chk("f.addr0", 32'(ram_addr_o), 32'h100); chk("f.wr0", 32'(ram_wr_o), 32'h0);
    if_addr_i = 32'h101;
    step(); chk("f.addr1", 32'(ram_addr_o), 32'h101); chk_ret("f.c3", 1'b0, 8'h00, 1'b0, 8'h00);
    if_addr_i = 32'h102;
    step(); chk_ret("f.b0", 1'b1, 8'h13, 1'b0, 8'h00);
    if_addr_i = 32'h103;
    step(); chk_ret("f.b1", 1'b1, 8'h05, 1'b0, 8'h00);
    if_r_i = 1'b0; if_busy_i = 1'b0;
    step(); chk_ret("f.b2", 1'b1, 8'h10, 1'b0, 8'h00); chk_grants("f.hold1", 1'b1, 1'b0);
    step(); chk_ret("f.b3", 1'b1, 8'h00, 1'b0, 8'h00); chk_grants("f.hold2", 1'b1, 1'b0);
    step(); chk_ret("f.end", 1'b0, 8'h00, 1'b0, 8'h00); chk_grants("f.rel", 1'b0, 1'b0);

    // MEM write 0xAB to 0x200, then read it back
    mem_w_i = 1'b1; mem_busy_i = 1'b1; mem_addr_i = 32'h200; mem_wdata_i = 8'hAB;
    step(); chk_grants("w.grant", 1'b0, 1'b1); chk("w.nodone", 32'(mem_wdone_o), 32'h0);
    step();
    chk("w.wdone", 32'(mem_wdone_o), 32'h1);
    chk("w.ram_wr", 32'(ram_wr_o), 32'h1);
    chk("w.ram_addr", 32'(ram_addr_o), 32'h200);
    chk("w.ram_dout", 32'(ram_dout_o), 32'hAB);
    mem_w_i = 1'b0; mem_r_i = 1'b1;
    step();
    chk("r.wdone", 32'(mem_wdone_o), 32'h0);
    chk("r.ram_wr", 32'(ram_wr_o), 32'h0);
    chk("r.ram_addr", 32'(ram_addr_o), 32'h200);
    mem_r_i = 1'b0; mem_busy_i = 1'b0;
    step(); chk_ret("r.c1", 1'b0, 8'h00, 1'b0, 8'h00);
    step(); chk_ret("r.data", 1'b0, 8'h00, 1'b1, 8'hAB); chk_grants("r.hold", 1'b0, 1'b1);
    step(); chk_grants("r.rel", 1'b0, 1'b0); chk("r.idle_wr", 32'(ram_wr_o), 32'h0);

    // Simultaneous requests from IDLE: MEM wins, IF gets the port after drain + one idle cycle
    if_r_i = 1'b1; if_busy_i = 1'b1; if_addr_i = 32'h101;
    mem_r_i = 1'b1; mem_addr_i = 32'h100;
    step(); chk_grants("t.mem_wins", 1'b0, 1'b1);
    step(); chk("t.addr", 32'(ram_addr_o), 32'h100);
    mem_r_i = 1'b0;
    step(); chk_ret("t.c1", 1'b0, 8'h00, 1'b0, 8'h00);
    step(); chk_ret("t.data", 1'b0, 8'h00, 1'b1, 8'h13); chk_grants("t.hold", 1'b0, 1'b1);
    step(); chk_grants("t.idle", 1'b0, 1'b0);
    step(); chk_grants("t.if_gets", 1'b1, 1'b0);

    // IF owns and stays busy while MEM requests: no grant until IF drains
    mem_r_i = 1'b1; mem_addr_i = 32'h102;
    step(); chk("o.addr", 32'(ram_addr_o), 32'h101);
    if_r_i = 1'b0;
    step(); chk_grants("o.busy", 1'b1, 1'b0); chk_ret("o.c1", 1'b0, 8'h00, 1'b0, 8'h00);
    step(); chk_ret("o.data", 1'b1, 8'h05, 1'b0, 8'h00); chk_grants("o.held", 1'b1, 1'b0);
    if_busy_i = 1'b0;
    step(); chk_grants("o.idle", 1'b0, 1'b0); chk_ret("o.nomis", 1'b0, 8'h00, 1'b0, 8'h00);
    step(); chk_grants("o.mem_gets", 1'b0, 1'b1);
    step(); chk("o.maddr", 32'(ram_addr_o), 32'h102);
    mem_r_i = 1'b0;
    step(); chk_ret("o.c2", 1'b0, 8'h00, 1'b0, 8'h00);
    step(); chk_ret("o.mdata", 1'b0, 8'h00, 1'b1, 8'h10);
    step(); chk_grants("o.rel", 1'b0, 1'b0);

    // Address wrap: 0x0002_0005 reads RAM[5]
    mem_r_i = 1'b1; mem_addr_i = 32'h0002_0005;
    step(); chk_grants("a.grant", 1'b0, 1'b1);
    step(); chk("a.wrap", 32'(ram_addr_o), 32'h00005);
    mem_r_i = 1'b0;
    step();
    step(); chk_ret("a.data", 1'b0, 8'h00, 1'b1, 8'h5A);
    step(); chk_grants("a.rel", 1'b0, 1'b0);

    // Reset one cycle after an IF read accept: outputs clear, in-flight byte dropped
    if_r_i = 1'b1; if_busy_i = 1'b0; if_addr_i = 32'h103;
    step(); chk_grants("x.grant", 1'b1, 1'b0);
    step(); chk("x.addr", 32'(ram_addr_o), 32'h103);
    if_r_i = 1'b0; rst = 1'b1;
    step();
    chk_grants("x.rst", 1'b0, 1'b0);
    chk_ret("x.rst", 1'b0, 8'h00, 1'b0, 8'h00);
    chk("x.if_data",  32'(if_data_o),   32'h0);
    chk("x.mem_data", 32'(mem_data_o),  32'h0);
    chk("x.wdone",    32'(mem_wdone_o), 32'h0);
    chk("x.ram_addr", 32'(ram_addr_o),  32'h0);
    chk("x.ram_wr",   32'(ram_wr_o),    32'h0);
    chk("x.ram_dout", 32'(ram_dout_o),  32'h0);
    rst = 1'b0;
    step(); chk("x.none1", 32'(if_rvalid_o), 32'h0);
    step(); chk("x.none2", 32'(if_rvalid_o), 32'h0);
    step(); chk("x.none3", 32'(if_rvalid_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
